// File: rtl/ila_pkg.sv
// ----------------------------------------------------------------------------
// ila_pkg
//   Shared definitions for the ILA capture-FIFO dump path.
//   - Default frame header / trailer bytes.
//   - FSM state encoding for the dumper.
//   - Elaboration-time ceil(log2()) helper used to size counters.
// ----------------------------------------------------------------------------
package ila_pkg;

    // Default frame delimiters; the top level exposes them as parameters.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] TRL_BYTE_DEF = 8'h5A;

    // Dumper FSM states. Explicit encodings keep waveforms readable.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for start
        HDR   = 3'd1,   // presenting the header byte
        LEN   = 3'd2,   // presenting the word count byte
        RD    = 3'd3,   // issuing the FIFO read strobe
        WAIT  = 3'd4,   // FIFO read latency; data lands at the end of this cycle
        SHIFT = 3'd5,   // serializer emits the word, MSB byte first
        TRL   = 3'd6,   // presenting the trailer byte
        DONE  = 3'd7    // one-cycle completion pulse
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1. Only used on constants.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ila_fifo_dumper_if.sv
// ----------------------------------------------------------------------------
// ila_fifo_dumper_if
//   Bundles the two buses the dumper sits between:
//   - FIFO read side : fifo_empty, fifo_cntr, fifo_dout (in), fifo_rd (out)
//   - UART TX stream : tx_data, tx_valid (out), tx_ready (in)
//   modport master : the dumper (drives fifo_rd and the TX byte stream)
//   modport slave  : the FIFO + UART side (drives status, read data, ready)
// Parameters
//   DW : FIFO word width (multiple of 8)
//   AW : FIFO address width; the fill level is AW+1 bits
// ----------------------------------------------------------------------------
interface ila_fifo_dumper_if #(
    parameter int DW = 64,
    parameter int AW = 5
);

    logic          fifo_empty;
    logic [AW:0]   fifo_cntr;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport master (
        input  fifo_empty,
        input  fifo_cntr,
        input  fifo_dout,
        output fifo_rd,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_cntr,
        output fifo_dout,
        input  fifo_rd,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/ila_fifo_dumper_serializer.sv
// ----------------------------------------------------------------------------
// ila_word_serializer
//   Holds one DW-bit word and presents it as DW/8 bytes, MSB byte first.
//   The byte index advances on each accepted byte and parks on the last byte
//   until the next load, so byte_out is always a stable registered value.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture din and restart at the MSB byte
//   din [DW]       : word to serialize
//   advance        : current byte was accepted downstream
//   byte_out [8]   : byte currently presented
//   last_accepted  : the final byte of the word was accepted this cycle
// ----------------------------------------------------------------------------
module ila_word_serializer
    import ila_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          advance,
    output logic [7:0]    byte_out,
    output logic          last_accepted
);

    localparam int NB = DW / 8;
    // A single-byte word still needs a 1-bit index register.
    localparam int CW = (clog2(NB) < 1) ? 1 : clog2(NB);

    logic [DW-1:0] word_reg;
    logic [CW-1:0] byte_cnt_reg;
    logic [7:0]    lanes [NB];
    logic          last_byte;

    // Lane 0 is the most significant byte, so the index counts up from 0.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lanes[gi] = word_reg[DW-1-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (load) begin
            word_reg     <= din;
            byte_cnt_reg <= '0;
        end else if (advance && !last_byte) begin
            byte_cnt_reg <= byte_cnt_reg + CW'(1);
        end
    end

    assign last_byte     = (byte_cnt_reg == CW'(NB - 1));
    assign byte_out      = lanes[byte_cnt_reg];
    assign last_accepted = advance && last_byte;

endmodule

// File: rtl/ila_fifo_dumper.sv
// ----------------------------------------------------------------------------
// ila_fifo_dumper
//   Read-side engine for the ILA capture FIFO. A start pulse snapshots the
//   FIFO fill level; exactly that many words are then read through the
//   FIFO's registered read port and sent to the UART TX block as a frame:
//     HDR_BYTE, count, N x (DW/8 bytes, MSB first), TRL_BYTE
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle request to dump; ignored unless idle
//   busy         : high whenever the FSM is not idle
//   done         : one-cycle pulse after the trailer byte is accepted
//   bus (master) : FIFO read port and valid/ready byte stream
// Parameters
//   DW, AW             : FIFO word and address widths (DW%8==0, AW+1<=8)
//   HDR_BYTE, TRL_BYTE : frame delimiters
// ----------------------------------------------------------------------------
module ila_fifo_dumper
    import ila_pkg::*;
#(
    parameter int         DW       = 64,
    parameter int         AW       = 5,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
    parameter logic [7:0] TRL_BYTE = TRL_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    ila_fifo_dumper_if.master  bus
);

    state_t      state_reg;
    logic [AW:0] n_words_reg;
    logic [AW:0] words_sent_reg;
    logic [AW:0] words_inc;
    logic [7:0]  ctrl_byte_reg;   // header / count / trailer byte
    logic        tx_valid_reg;
    logic        done_reg;

    logic        xfer;
    logic        ser_load;
    logic        ser_advance;
    logic [7:0]  ser_byte;
    logic        ser_last_accepted;

    assign xfer        = tx_valid_reg && bus.tx_ready;
    // The FIFO read data is valid during WAIT, so capture it at its end.
    assign ser_load    = (state_reg == WAIT);
    assign ser_advance = (state_reg == SHIFT) && xfer;
    assign words_inc   = words_sent_reg + (AW+1)'(1);

    ila_word_serializer #(
        .DW (DW)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .load          (ser_load),
        .din           (bus.fifo_dout),
        .advance       (ser_advance),
        .byte_out      (ser_byte),
        .last_accepted (ser_last_accepted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            n_words_reg    <= '0;
            words_sent_reg <= '0;
            ctrl_byte_reg  <= '0;
            tx_valid_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Snapshot: later FIFO writes never lengthen this dump.
                        n_words_reg    <= bus.fifo_cntr;
                        words_sent_reg <= '0;
                        ctrl_byte_reg  <= HDR_BYTE;
                        tx_valid_reg   <= 1'b1;
                        state_reg      <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        ctrl_byte_reg <= 8'(n_words_reg);
                        state_reg     <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        if (n_words_reg != '0) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= RD;
                        end else begin
                            ctrl_byte_reg <= TRL_BYTE;
                            state_reg     <= TRL;
                        end
                    end
                end
                RD: begin
                    // fifo_rd is asserted combinationally in this state.
                    if (!bus.fifo_empty) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    tx_valid_reg <= 1'b1;
                    state_reg    <= SHIFT;
                end
                SHIFT: begin
                    if (ser_last_accepted) begin
                        words_sent_reg <= words_inc;
                        if (words_inc < n_words_reg) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= RD;
                        end else begin
                            ctrl_byte_reg <= TRL_BYTE;
                            state_reg     <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (xfer) begin
                        tx_valid_reg  <= 1'b0;
                        ctrl_byte_reg <= '0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The read strobe is gated by the live empty flag so it can never fire
    // into an empty FIFO, even if the flag changes while waiting in RD.
    assign bus.fifo_rd  = (state_reg == RD) && !bus.fifo_empty;
    assign bus.tx_valid = tx_valid_reg;
    assign bus.tx_data  = (state_reg == SHIFT) ? ser_byte : ctrl_byte_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;

endmodule
